// File: rtl/segasys1_sound_cmd_if.sv
// Main-CPU / sound-CPU side signals of the Sega System 1 sound command bridge.
// master = CPU-side stimulus, slave = the bridge itself.
interface segasys1_sound_cmd_if;
   logic       SNDRQ;
   logic [7:0] SNDNO;
   logic       PAUSE_N;
   logic       S_RD;
   logic       S_IACK;
   logic [7:0] S_DO;
   logic       S_NMI_N;
   logic       S_INT_N;
   logic       BUSY;
   logic       OVF;

   modport master (
      output SNDRQ, SNDNO, PAUSE_N, S_RD, S_IACK,
      input  S_DO, S_NMI_N, S_INT_N, BUSY, OVF
   );

   modport slave (
      input  SNDRQ, SNDNO, PAUSE_N, S_RD, S_IACK,
      output S_DO, S_NMI_N, S_INT_N, BUSY, OVF
   );
endinterface

// File: rtl/segasys1_sound_cmd.sv
// Main-to-sound command bridge: command latch (or queue with CMD_FIFO_EN defined),
// sound-CPU NMI on pending command, and periodic acknowledged sound-CPU INT.
module segasys1_sound_cmd #(
   parameter int TIMER_DIV  = 166667,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 CLK40M,
   input  logic                 RESET_N,
   segasys1_sound_cmd_if.slave  bus
);

   localparam logic [17:0] TMR_LAST = 18'(TIMER_DIV - 1);

   logic        r_rq_d;
   logic        w_wr;
   logic [17:0] r_tmr;
   logic        w_tc;
   logic        r_int_n;

   // rq_d resets high so a strobe already asserted at reset release is not a new command.
   assign w_wr = bus.SNDRQ & ~r_rq_d;
   assign w_tc = bus.PAUSE_N & (r_tmr == TMR_LAST);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge CLK40M or negedge RESET_N) begin
      if (!RESET_N) r_rq_d <= 1'b1;
      else          r_rq_d <= bus.SNDRQ;
   end

   always_ff @(posedge CLK40M or negedge RESET_N) begin
      if (!RESET_N)          r_tmr <= '0;
      else if (bus.PAUSE_N)  r_tmr <= (r_tmr == TMR_LAST) ? '0 : r_tmr + 18'd1;
   end

   // Terminal count beats a same-cycle acknowledge; unacknowledged periods merge.
   always_ff @(posedge CLK40M or negedge RESET_N) begin
      if (!RESET_N)         r_int_n <= 1'b1;
      else if (w_tc)        r_int_n <= 1'b0;
      else if (bus.S_IACK)  r_int_n <= 1'b1;
   end

   assign bus.S_INT_N = r_int_n;

`ifdef CMD_FIFO_EN
   localparam int               AW   = $clog2(FIFO_DEPTH);
   localparam int               CW   = AW + 1;
   localparam logic [CW-1:0]    FULL = CW'(FIFO_DEPTH);

   logic [7:0]    r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wp;
   logic [AW-1:0] r_rp;
   logic [CW-1:0] r_cnt;
   logic          r_ovf;
   logic          w_empty;
   logic          w_full;
   logic          w_pop;
   logic          w_push;

   assign w_empty = (r_cnt == '0);
   assign w_full  = (r_cnt == FULL);
   assign w_pop   = bus.S_RD & ~w_empty;
   // A pop in the same cycle frees the slot, so a full queue still accepts the write.
   assign w_push  = w_wr & (~w_full | w_pop);

   // NOTE: queue storage is deliberately not reset; r_cnt alone defines which entries are valid.
   always_ff @(posedge CLK40M) begin
      if (w_push) r_mem[r_wp] <= bus.SNDNO;
   end

   always_ff @(posedge CLK40M or negedge RESET_N) begin
      if (!RESET_N) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
         r_ovf <= 1'b0;
      end else begin
         if (w_push) r_wp <= r_wp + AW'(1);
         if (w_pop)  r_rp <= r_rp + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + CW'(1);
            2'b01:   r_cnt <= r_cnt - CW'(1);
            default: r_cnt <= r_cnt;
         endcase
         if (w_wr && !w_push) r_ovf <= 1'b1;
      end
   end

   assign bus.S_DO    = w_empty ? 8'h00 : r_mem[r_rp];
   assign bus.S_NMI_N = w_empty;
   assign bus.BUSY    = w_full;
   assign bus.OVF     = r_ovf;
`else
   // Queue depth only matters in queued mode.
   localparam int unused_fifo_depth = FIFO_DEPTH;

   logic [7:0] r_do;
   logic       r_pend;

   // A new write wins over a same-cycle read and simply overwrites a pending command.
   always_ff @(posedge CLK40M or negedge RESET_N) begin
      if (!RESET_N) begin
         r_do   <= 8'h00;
         r_pend <= 1'b0;
      end else if (w_wr) begin
         r_do   <= bus.SNDNO;
         r_pend <= 1'b1;
      end else if (bus.S_RD) begin
         r_pend <= 1'b0;
      end
   end

   assign bus.S_DO    = r_do;
   assign bus.S_NMI_N = ~r_pend;
   assign bus.BUSY    = r_pend;
   assign bus.OVF     = 1'b0;
`endif

endmodule

// File: tb/tb_segasys1_sound_cmd.sv
// Bench for segasys1_sound_cmd: directed scenarios plus random traffic against a
// transaction-level model (command list/queue, active-cycle counting for the INT timer).
module tb_segasys1_sound_cmd;

   localparam int DIV   = 16;
   localparam int DEPTH = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   segasys1_sound_cmd_if bus ();

   segasys1_sound_cmd #(
      .TIMER_DIV  (DIV),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .CLK40M  (clk),
      .RESET_N (rst_n),
      .bus     (bus.slave)
   );

   int vectors     = 0;
   int miscompares = 0;

   // Reference model state
   bit         m_rq_prev;
   logic [7:0] m_do;
   bit         m_pend;
   logic [7:0] m_q[$];
   bit         m_ovf;
   bit         m_int;
   int         m_act;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_rq_prev = 1'b1;
      m_do      = 8'h00;
      m_pend    = 1'b0;
      m_q.delete();
      m_ovf     = 1'b0;
      m_int     = 1'b0;
      m_act     = 0;
   endtask

   task automatic check_model(input string tag);
      logic [7:0] e_do;
      logic       e_nmi_n, e_busy, e_ovf;
`ifdef CMD_FIFO_EN
      e_do    = (m_q.size() != 0) ? m_q[0] : 8'h00;
      e_nmi_n = (m_q.size() == 0);
      e_busy  = (m_q.size() == DEPTH);
      e_ovf   = m_ovf;
`else
      e_do    = m_do;
      e_nmi_n = ~m_pend;
      e_busy  = m_pend;
      e_ovf   = 1'b0;
`endif
      check({tag, ".do"},   bus.S_DO,           e_do);
      check({tag, ".nmi"},  {7'd0, bus.S_NMI_N}, {7'd0, e_nmi_n});
      check({tag, ".int"},  {7'd0, bus.S_INT_N}, {7'd0, ~m_int});
      check({tag, ".busy"}, {7'd0, bus.BUSY},    {7'd0, e_busy});
      check({tag, ".ovf"},  {7'd0, bus.OVF},     {7'd0, e_ovf});
   endtask

   // One clock: advance the model with the inputs present at the edge, then compare.
   task automatic tick(input string tag);
      bit wr;
      @(posedge clk);
      wr        = bus.SNDRQ && !m_rq_prev;
      m_rq_prev = bus.SNDRQ;
`ifdef CMD_FIFO_EN
      if (bus.S_RD && m_q.size() != 0) void'(m_q.pop_front());
      if (wr) begin
         if (m_q.size() < DEPTH) m_q.push_back(bus.SNDNO);
         else                    m_ovf = 1'b1;
      end
`else
      if (wr) begin
         m_do   = bus.SNDNO;
         m_pend = 1'b1;
      end else if (bus.S_RD) begin
         m_pend = 1'b0;
      end
`endif
      if (bus.PAUSE_N) m_act++;
      if (bus.PAUSE_N && (m_act % DIV == 0)) m_int = 1'b1;
      else if (bus.S_IACK)                    m_int = 1'b0;
      #1;
      check_model(tag);
   endtask

   task automatic step(input string tag, input bit rq, input logic [7:0] no,
                       input bit rd, input bit ack, input bit ps);
      bus.SNDRQ   = rq;
      bus.SNDNO   = no;
      bus.S_RD    = rd;
      bus.S_IACK  = ack;
      bus.PAUSE_N = ps;
      tick(tag);
   endtask

   // Asserted mid-cycle: outputs must reach reset values without waiting for a clock.
   task automatic apply_reset(input string tag);
      rst_n = 1'b0;
      #1;
      model_reset();
      check({tag, ".do"},   bus.S_DO,           8'h00);
      check({tag, ".nmi"},  {7'd0, bus.S_NMI_N}, 8'h01);
      check({tag, ".int"},  {7'd0, bus.S_INT_N}, 8'h01);
      check({tag, ".busy"}, {7'd0, bus.BUSY},    8'h00);
      check({tag, ".ovf"},  {7'd0, bus.OVF},     8'h00);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      bus.SNDRQ   = 1'b1;
      bus.SNDNO   = 8'h00;
      bus.S_RD    = 1'b0;
      bus.S_IACK  = 1'b0;
      bus.PAUSE_N = 1'b1;
      model_reset();
      #12;

      // 1. Strobe held across reset release is not a command; a fresh edge is.
      apply_reset("t1_rst");
      repeat (3) step("t1_hold", 1, 8'hEE, 0, 0, 1);
      check("t1_no_nmi", {7'd0, bus.S_NMI_N}, 8'h01);
      step("t1_drop", 0, 8'h00, 0, 0, 1);
      step("t1_wr", 1, 8'h5A, 0, 0, 1);
      check("t1_do", bus.S_DO, 8'h5A);
      check("t1_nmi_lo", {7'd0, bus.S_NMI_N}, 8'h00);
      step("t1_rd", 1, 8'h00, 1, 0, 1);
      check("t1_nmi_hi", {7'd0, bus.S_NMI_N}, 8'h01);
`ifndef CMD_FIFO_EN
      check("t1_busy_clr", {7'd0, bus.BUSY}, 8'h00);
`endif

      // 2. Overwrite before read, then write colliding with a read.
      step("t2", 0, 8'h00, 0, 0, 1);
      step("t2", 1, 8'h11, 0, 0, 1);
      step("t2", 0, 8'h00, 0, 0, 1);
      step("t2", 1, 8'h22, 0, 0, 1);
`ifndef CMD_FIFO_EN
      check("t2_overwrite", bus.S_DO, 8'h22);
      check("t2_one_nmi", {7'd0, bus.S_NMI_N}, 8'h00);
`endif
      step("t2", 0, 8'h00, 0, 0, 1);
      step("t2_wr_rd", 1, 8'h33, 1, 0, 1);
`ifndef CMD_FIFO_EN
      check("t2_wr_wins", bus.S_DO, 8'h33);
      check("t2_nmi_kept", {7'd0, bus.S_NMI_N}, 8'h00);
`endif
      repeat (4) step("t2_drain", 0, 8'h00, 1, 0, 1);

      // 3. INT timer: first period, merge of unacknowledged periods, pause.
      bus.SNDRQ = 1'b0;
      apply_reset("t3_rst");
      for (int i = 1; i < DIV; i++) begin
         step("t3_wait", 0, 8'h00, 0, 0, 1);
         check("t3_int_idle", {7'd0, bus.S_INT_N}, 8'h01);
      end
      step("t3_tc", 0, 8'h00, 0, 0, 1);
      check("t3_int_first", {7'd0, bus.S_INT_N}, 8'h00);
      step("t3_ack", 0, 8'h00, 0, 1, 1);
      check("t3_int_ack", {7'd0, bus.S_INT_N}, 8'h01);
      repeat (40) step("t3_noack", 0, 8'h00, 0, 0, 1);
      check("t3_int_held", {7'd0, bus.S_INT_N}, 8'h00);
      step("t3_ack2", 0, 8'h00, 0, 1, 1);
      check("t3_int_ack2", {7'd0, bus.S_INT_N}, 8'h01);
      repeat (10) step("t3_pause", 0, 8'h00, 0, 0, 0);
      repeat (5) step("t3_resume", 0, 8'h00, 0, 0, 1);
      check("t3_int_delayed", {7'd0, bus.S_INT_N}, 8'h01);
      step("t3_tc2", 0, 8'h00, 0, 0, 1);
      check("t3_int_after_pause", {7'd0, bus.S_INT_N}, 8'h00);

`ifdef CMD_FIFO_EN
      // 4. Fill, overflow, drain in order.
      apply_reset("t4_rst");
      for (int i = 0; i < 5; i++) begin
         step("t4_gap", 0, 8'h00, 0, 0, 1);
         step("t4_push", 1, 8'(8'hA0 + i), 0, 0, 1);
         if (i == 3) check("t4_full", {7'd0, bus.BUSY}, 8'h01);
      end
      check("t4_ovf", {7'd0, bus.OVF}, 8'h01);
      for (int i = 0; i < 4; i++) begin
         check("t4_head", bus.S_DO, 8'(8'hA0 + i));
         step("t4_pop", 0, 8'h00, 1, 0, 1);
      end
      check("t4_nmi_empty", {7'd0, bus.S_NMI_N}, 8'h01);

      // 5. Full queue with simultaneous push and pop: nothing lost.
      apply_reset("t5_rst");
      for (int i = 0; i < 4; i++) begin
         step("t5_gap", 0, 8'h00, 0, 0, 1);
         step("t5_push", 1, 8'(8'hB0 + i), 0, 0, 1);
      end
      step("t5_gap", 0, 8'h00, 0, 0, 1);
      step("t5_pushpop", 1, 8'hB4, 1, 0, 1);
      check("t5_no_ovf", {7'd0, bus.OVF}, 8'h00);
      check("t5_still_full", {7'd0, bus.BUSY}, 8'h01);
      for (int i = 1; i < 5; i++) begin
         check("t5_order", bus.S_DO, 8'(8'hB0 + i));
         step("t5_pop", 0, 8'h00, 1, 0, 1);
      end
`endif

      // 6. Reset with both NMI and INT pending.
      apply_reset("t6_rst0");
      step("t6", 0, 8'h00, 0, 0, 1);
      step("t6", 1, 8'h77, 0, 0, 1);
      repeat (DIV) step("t6_wait", 1, 8'h00, 0, 0, 1);
      check("t6_nmi_pend", {7'd0, bus.S_NMI_N}, 8'h00);
      check("t6_int_pend", {7'd0, bus.S_INT_N}, 8'h00);
      apply_reset("t6_rst");

      // Random traffic against the model, with one reset in the middle.
      bus.SNDRQ = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (i == 200) apply_reset("rnd_rst");
         step("rnd",
              1'($urandom_range(0, 1)),
              8'($urandom),
              ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 5) == 0),
              ($urandom_range(0, 7) != 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
